pd_power_sequencer: RTL and testbench
=====================================

Name: pd_power_sequencer

Overview:
- Synthesisable power-management sequencer for NUM_PD power domains.
- Generates clock-enable, isolation, retention, power-switch and one-hot voltage-select controls.
- Accepts one domain request at a time over a valid/ready interface.
- Sits in rtl_top beside the domain logic; its outputs drive the UPF control nets directly.

Parameters:
- NUM_PD, 3, number of power domains (>=1).
- NUM_VLVL, 3, voltage levels per domain; vsel is one-hot; level 0 = low.
- STEP_CYC, 2, clock cycles between consecutive sequencing actions (>=1).
- CNT_W, 8, step-counter width; STEP_CYC < 2**CNT_W.
- RST_PWR, {NUM_PD{1'b1}}, per-domain power state after reset.

Ports:
- clk  in  1  sequencer clock.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- req_valid  in  1  request valid.
- req_ready  out  1  high when idle; transfer = req_valid & req_ready at posedge clk.
- req_pd  in  $clog2(NUM_PD) (min 1)  target domain index.
- req_op  in  2  00 power-off, 01 power-on, 10 set-voltage, 11 reserved.
- req_vlvl  in  $clog2(NUM_VLVL) (min 1)  voltage level for set-voltage.
- ret_cfg  in  NUM_PD  per-domain retention enable (static).
- iso_cfg  in  NUM_PD  per-domain isolation enable (static).
- clk_en  out  NUM_PD  domain clock window.
- iso  out  NUM_PD  isolation enable.
- ret  out  NUM_PD  retention save/hold.
- pwr  out  NUM_PD  power switch; 1 = on.
- vsel  out  NUM_PD*NUM_VLVL  one-hot level per domain; domain d occupies bits [d*NUM_VLVL +: NUM_VLVL].
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values:
  - pwr = RST_PWR, clk_en = RST_PWR, iso = 0, ret = 0.
  - vsel = level 0 for every domain.
  - req_ready = 1, done = 0, err = 0.
  - FSM in IDLE.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous); no sequence resumes.
- FSM states: IDLE, CLK_STOP, ISO_ON, RET_ON, PWR_OFF, PWR_ON, RET_OFF, ISO_OFF, CLK_START, V_MAKE, V_BREAK.
- req_ready = 1 only in IDLE.
- Each action is registered. The first action is visible the cycle after acceptance; each later action follows STEP_CYC cycles after the previous one.
- Power-off: CLK_STOP (clk_en=0) -> ISO_ON (iso=1) -> RET_ON (ret=1) -> PWR_OFF (pwr=0, done).
  - ISO_ON is skipped when iso_cfg=0; RET_ON is skipped when ret_cfg=0. Skipped steps take zero cycles.
  - Example: STEP_CYC=2, all enabled, accept at edge k -> clk_en falls at k+1, iso at k+3, ret at k+5, pwr at k+7 with done.
- Power-on: PWR_ON (pwr=1) -> RET_OFF (ret=0) -> ISO_OFF (iso=0) -> CLK_START (clk_en=1, done). Same skip and step rules.
- Set-voltage on a powered domain:
  - CLK_STOP -> V_MAKE (new level bit set, old bit kept) -> V_BREAK (old bit cleared) -> CLK_START (done).
  - This is make-before-break: vsel is never all-zero for a powered domain.
  - If the requested level equals the current level: done the cycle after acceptance, no output change.
- Rejected requests (accepted, one err pulse next cycle, no output change, FSM stays IDLE):
  - req_pd >= NUM_PD.
  - req_op = 11.
  - req_vlvl >= NUM_VLVL.
  - Power-off of a domain that is already off; power-on of a domain that is already on.
  - Set-voltage on a domain that is off.
- vsel of a powered-off domain holds its last level and is restored unchanged at power-on.
- Exactly one domain is sequenced at a time; other domains' outputs never change during a sequence.
- ret_cfg and iso_cfg are sampled at acceptance and held for the whole sequence.

Optional Feature:
- Macro PD_SEQ_PWR_ACK_EN.
- Defined:
  - Adds input pwr_ack[NUM_PD] and parameter ACK_TMO (default 64).
  - PWR_OFF waits for pwr_ack[d]=0 and PWR_ON waits for pwr_ack[d]=1 before continuing.
  - If the ack is not seen within ACK_TMO cycles: err pulses and the FSM returns to IDLE. Outputs hold their current values; on a power-on timeout the domain stays isolated and in retention.
- Undefined: no pwr_ack port; fixed STEP_CYC wait.

Test Plan:
- Reset, NUM_PD=3, STEP_CYC=2, ret_cfg=3'b100, iso_cfg=3'b001; power-off pd0 accepted at edge k -> clk_en[0]=0 at k+1, iso[0]=1 at k+3, pwr[0]=0 plus done at k+5; ret[0] stays 0.
- Power-off then power-on pd2 -> ret[2]=1 before pwr[2]=0; on power-on, pwr[2]=1 then ret[2]=0 STEP_CYC later; clk_en[2]=1 last; other domains' outputs constant.
- Set-voltage pd1 from level 0 to 2 -> clk_en[1]=0; vsel[1]=3'b101 for STEP_CYC cycles, then 3'b100; clk_en[1]=1 and done; vsel[1] never 3'b000.
- Error cases, each producing one err pulse and no output change: req_pd=3, req_op=11, power-on of an on domain, set-voltage of an off domain.
- reset driven low at k+4 of a power-off sequence -> all outputs at reset values in the same cycle; req_ready=1 after release.
- With PD_SEQ_PWR_ACK_EN and pwr_ack held at 1 during power-off -> err after ACK_TMO=64 cycles, pwr[0]=0 and iso[0]=1 held, FSM back in IDLE.

Source files
------------

// File: rtl/pd_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pd_power_sequencer
// Purpose  : Sequences clock, isolation, retention, power-switch and voltage
//            controls for NUM_PD domains. Optional macro PD_SEQ_PWR_ACK_EN
//            adds pwr_ack handshaking with timeout ACK_TMO.
// Revision : 1.0
// ============================================================================
module pd_power_sequencer #(
  parameter int                NUM_PD   = 3,
  parameter int                NUM_VLVL = 3,
  parameter int                STEP_CYC = 2,
  parameter int                CNT_W    = 8,
  parameter logic [NUM_PD-1:0] RST_PWR  = {NUM_PD{1'b1}}
`ifdef PD_SEQ_PWR_ACK_EN
  ,
  parameter int                ACK_TMO  = 64
`endif
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [((NUM_PD > 1) ? $clog2(NUM_PD) : 1)-1:0]     req_pd,
  input  logic [1:0]                                     req_op,
  input  logic [((NUM_VLVL > 1) ? $clog2(NUM_VLVL) : 1)-1:0] req_vlvl,
  input  logic [NUM_PD-1:0]                              ret_cfg,
  input  logic [NUM_PD-1:0]                              iso_cfg,
`ifdef PD_SEQ_PWR_ACK_EN
  input  logic [NUM_PD-1:0]                              pwr_ack,
`endif
  output logic [NUM_PD-1:0]                              clk_en,
  output logic [NUM_PD-1:0]                              iso,
  output logic [NUM_PD-1:0]                              ret,
  output logic [NUM_PD-1:0]                              pwr,
  output logic [NUM_PD*NUM_VLVL-1:0]                     vsel,
  output logic                                           done,
  output logic                                           err
);

  localparam int PD_W = (NUM_PD > 1) ? $clog2(NUM_PD) : 1;
  localparam int VL_W = (NUM_VLVL > 1) ? $clog2(NUM_VLVL) : 1;
  localparam int VS_W = NUM_PD * NUM_VLVL;
  localparam logic [VS_W-1:0]  VSEL_RST    = {NUM_PD{NUM_VLVL'(1)}};
  localparam logic [CNT_W-1:0] STEP_RELOAD = CNT_W'(STEP_CYC - 1);
  localparam logic [1:0] OP_OFF  = 2'b00;
  localparam logic [1:0] OP_ON   = 2'b01;
  localparam logic [1:0] OP_VSET = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [3:0] {
    IDLE, CLK_STOP, ISO_ON, RET_ON, PWR_OFF, PWR_ON,
    RET_OFF, ISO_OFF, CLK_START, V_MAKE, V_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PD_W-1:0]   pd_q, pd_d;
  logic [1:0]        op_q, op_d;
  logic [VL_W-1:0]   vlvl_q, vlvl_d;
  logic              ret_en_q, ret_en_d;
  logic              iso_en_q, iso_en_d;
  logic [NUM_PD-1:0] clk_en_q, clk_en_d;
  logic [NUM_PD-1:0] iso_q, iso_d;
  logic [NUM_PD-1:0] ret_q, ret_d;
  logic [NUM_PD-1:0] pwr_q, pwr_d;
  logic [VS_W-1:0]   vsel_q, vsel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              done_pend_q, done_pend_d;
  logic              err_pend_q, err_pend_d;

  logic [NUM_PD-1:0]   w_req_sel, w_sel;
  logic [NUM_VLVL-1:0] w_req_oh, w_new_oh, w_req_vsel;
  logic [VS_W-1:0]     w_vmask, w_vnew;
  logic                w_pd_ok, w_vl_ok, w_req_on, w_reject, w_same_lvl;

`ifdef PD_SEQ_PWR_ACK_EN
  localparam int TMO_W = $clog2(ACK_TMO + 1);
  logic             ack_wait_q, ack_wait_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             w_ack, w_tmo;
  assign w_ack = |(pwr_ack & w_sel);
  assign w_tmo = (tmo_q == TMO_W'(ACK_TMO - 1));
`endif

  always_comb begin : p_decode
    w_req_sel  = '0;
    w_sel      = '0;
    w_req_oh   = '0;
    w_new_oh   = '0;
    w_req_vsel = '0;
    w_vmask    = '0;
    w_vnew     = '0;
    for (int l = 0; l < NUM_VLVL; l++) begin
      w_req_oh[l] = (req_vlvl == VL_W'(l));
      w_new_oh[l] = (vlvl_q == VL_W'(l));
    end
    for (int d = 0; d < NUM_PD; d++) begin
      w_req_sel[d] = (req_pd == PD_W'(d));
      w_sel[d]     = (pd_q == PD_W'(d));
      if (w_req_sel[d]) w_req_vsel = vsel_q[d*NUM_VLVL +: NUM_VLVL];
      if (w_sel[d]) begin
        w_vmask[d*NUM_VLVL +: NUM_VLVL] = '1;
        w_vnew[d*NUM_VLVL +: NUM_VLVL]  = w_new_oh;
      end
    end
  end

  // An out-of-range index or level decodes to an all-zero one-hot.
  assign w_pd_ok    = |w_req_sel;
  assign w_vl_ok    = |w_req_oh;
  assign w_req_on   = |(w_req_sel & pwr_q);
  assign w_reject   = !w_pd_ok || !w_vl_ok || (req_op == OP_RSVD) ||
                      ((req_op == OP_OFF)  && !w_req_on) ||
                      ((req_op == OP_ON)   &&  w_req_on) ||
                      ((req_op == OP_VSET) && !w_req_on);
  assign w_same_lvl = (req_op == OP_VSET) && (w_req_vsel == w_req_oh);

  always_comb begin : p_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    pd_d        = pd_q;
    op_d        = op_q;
    vlvl_d      = vlvl_q;
    ret_en_d    = ret_en_q;
    iso_en_d    = iso_en_q;
    clk_en_d    = clk_en_q;
    iso_d       = iso_q;
    ret_d       = ret_q;
    pwr_d       = pwr_q;
    vsel_d      = vsel_q;
    done_d      = done_pend_q;
    err_d       = err_pend_q;
    done_pend_d = 1'b0;
    err_pend_d  = 1'b0;
`ifdef PD_SEQ_PWR_ACK_EN
    ack_wait_d  = ack_wait_q;
    tmo_d       = tmo_q;
`endif
    if (state_q == IDLE) begin
      if (req_valid) begin
        if (w_reject) begin
          err_pend_d = 1'b1;
        end else if (w_same_lvl) begin
          done_pend_d = 1'b1;
        end else begin
          pd_d     = req_pd;
          op_d     = req_op;
          vlvl_d   = req_vlvl;
          ret_en_d = |(ret_cfg & w_req_sel);
          iso_en_d = |(iso_cfg & w_req_sel);
          cnt_d    = '0;
          state_d  = (req_op == OP_ON) ? PWR_ON : CLK_STOP;
        end
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = STEP_RELOAD;
      case (state_q)
        CLK_STOP: begin
          clk_en_d = clk_en_q & ~w_sel;
          if (op_q == OP_VSET) state_d = V_MAKE;
          else if (iso_en_q)   state_d = ISO_ON;
          else if (ret_en_q)   state_d = RET_ON;
          else                 state_d = PWR_OFF;
        end
        ISO_ON: begin
          iso_d   = iso_q | w_sel;
          state_d = ret_en_q ? RET_ON : PWR_OFF;
        end
        RET_ON: begin
          ret_d   = ret_q | w_sel;
          state_d = PWR_OFF;
        end
        PWR_OFF: begin
`ifdef PD_SEQ_PWR_ACK_EN
          if (!ack_wait_q) begin
            pwr_d      = pwr_q & ~w_sel;
            ack_wait_d = 1'b1;
            tmo_d      = '0;
            cnt_d      = '0;
          end else if (!w_ack) begin
            ack_wait_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else if (w_tmo) begin
            ack_wait_d = 1'b0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
            cnt_d = '0;
          end
`else
          pwr_d   = pwr_q & ~w_sel;
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end
        PWR_ON: begin
`ifdef PD_SEQ_PWR_ACK_EN
          if (!ack_wait_q) begin
            pwr_d      = pwr_q | w_sel;
            ack_wait_d = 1'b1;
            tmo_d      = '0;
            cnt_d      = '0;
          end else if (w_ack) begin
            ack_wait_d = 1'b0;
            if (ret_en_q)      state_d = RET_OFF;
            else if (iso_en_q) state_d = ISO_OFF;
            else               state_d = CLK_START;
          end else if (w_tmo) begin
            ack_wait_d = 1'b0;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
            cnt_d = '0;
          end
`else
          pwr_d = pwr_q | w_sel;
          if (ret_en_q)      state_d = RET_OFF;
          else if (iso_en_q) state_d = ISO_OFF;
          else               state_d = CLK_START;
`endif
        end
        RET_OFF: begin
          ret_d   = ret_q & ~w_sel;
          state_d = iso_en_q ? ISO_OFF : CLK_START;
        end
        ISO_OFF: begin
          iso_d   = iso_q & ~w_sel;
          state_d = CLK_START;
        end
        CLK_START: begin
          clk_en_d = clk_en_q | w_sel;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        // Make-before-break: the new level joins the old one before the old drops.
        V_MAKE: begin
          vsel_d  = vsel_q | w_vnew;
          state_d = V_BREAK;
        end
        V_BREAK: begin
          vsel_d  = (vsel_q & ~w_vmask) | w_vnew;
          state_d = CLK_START;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pd_q        <= '0;
      op_q        <= '0;
      vlvl_q      <= '0;
      ret_en_q    <= 1'b0;
      iso_en_q    <= 1'b0;
      clk_en_q    <= RST_PWR;
      iso_q       <= '0;
      ret_q       <= '0;
      pwr_q       <= RST_PWR;
      vsel_q      <= VSEL_RST;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
`ifdef PD_SEQ_PWR_ACK_EN
      ack_wait_q  <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pd_q        <= pd_d;
      op_q        <= op_d;
      vlvl_q      <= vlvl_d;
      ret_en_q    <= ret_en_d;
      iso_en_q    <= iso_en_d;
      clk_en_q    <= clk_en_d;
      iso_q       <= iso_d;
      ret_q       <= ret_d;
      pwr_q       <= pwr_d;
      vsel_q      <= vsel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      done_pend_q <= done_pend_d;
      err_pend_q  <= err_pend_d;
`ifdef PD_SEQ_PWR_ACK_EN
      ack_wait_q  <= ack_wait_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign clk_en    = clk_en_q;
  assign iso       = iso_q;
  assign ret       = ret_q;
  assign pwr       = pwr_q;
  assign vsel      = vsel_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pd_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pd_power_sequencer
// Purpose  : Directed self-checking bench for pd_power_sequencer (default
//            build, NUM_PD=3, NUM_VLVL=3, STEP_CYC=2).
// Revision : 1.0
// ============================================================================
module tb_pd_power_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_pd;
  logic [1:0] req_op;
  logic [1:0] req_vlvl;
  logic [2:0] ret_cfg;
  logic [2:0] iso_cfg;
  logic [2:0] clk_en, iso, ret, pwr;
  logic [8:0] vsel;
  logic       done, err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] pd;
    logic [1:0] op;
    logic [1:0] vl;
    logic       e_err;
    logic       e_done;
    logic [2:0] e_pwr;
  } vec_t;

  vec_t vt[7];

  pd_power_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pd    (req_pd),
    .req_op    (req_op),
    .req_vlvl  (req_vlvl),
    .ret_cfg   (ret_cfg),
    .iso_cfg   (iso_cfg),
    .clk_en    (clk_en),
    .iso       (iso),
    .ret       (ret),
    .pwr       (pwr),
    .vsel      (vsel),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic seq_chk(input string tag, input int j,
                         input logic [2:0] e_clk, input logic [2:0] e_iso,
                         input logic [2:0] e_ret, input logic [2:0] e_pwr,
                         input logic [8:0] e_vsel, input logic e_done,
                         input logic e_rdy);
    chk($sformatf("%s j%0d clk_en", tag, j), clk_en, e_clk);
    chk($sformatf("%s j%0d iso", tag, j), iso, e_iso);
    chk($sformatf("%s j%0d ret", tag, j), ret, e_ret);
    chk($sformatf("%s j%0d pwr", tag, j), pwr, e_pwr);
    chk($sformatf("%s j%0d vsel", tag, j), vsel, e_vsel);
    chk($sformatf("%s j%0d done", tag, j), done, e_done);
    chk($sformatf("%s j%0d err", tag, j), err, 1'b0);
    chk($sformatf("%s j%0d ready", tag, j), req_ready, e_rdy);
  endtask

  // Presents one request for exactly one rising edge (edge k).
  task automatic issue(input logic [1:0] pd, input logic [1:0] op, input logic [1:0] vl);
    @(negedge clk);
    chk("ready before request", req_ready, 1'b1);
    req_valid = 1'b1;
    req_pd    = pd;
    req_op    = op;
    req_vlvl  = vl;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    vt[0] = '{pd: 2'd3, op: 2'b01, vl: 2'd0, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[1] = '{pd: 2'd1, op: 2'b11, vl: 2'd0, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[2] = '{pd: 2'd1, op: 2'b01, vl: 2'd0, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[3] = '{pd: 2'd0, op: 2'b10, vl: 2'd1, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[4] = '{pd: 2'd0, op: 2'b00, vl: 2'd0, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[5] = '{pd: 2'd1, op: 2'b10, vl: 2'd3, e_err: 1'b1, e_done: 1'b0, e_pwr: 3'b110};
    vt[6] = '{pd: 2'd2, op: 2'b10, vl: 2'd0, e_err: 1'b0, e_done: 1'b1, e_pwr: 3'b110};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_pd    = '0;
    req_op    = '0;
    req_vlvl  = '0;
    ret_cfg   = 3'b100;
    iso_cfg   = 3'b001;
    repeat (3) @(negedge clk);
    seq_chk("reset", 0, 3'b111, 3'b000, 3'b000, 3'b111, 9'b001_001_001, 1'b0, 1'b1);
    reset = 1'b1;

    // pd0 off: iso enabled, retention skipped
    issue(2'd0, 2'b00, 2'd0);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      seq_chk("off_pd0", j, (j >= 1) ? 3'b110 : 3'b111, (j >= 3) ? 3'b001 : 3'b000,
              3'b000, (j >= 5) ? 3'b110 : 3'b111, 9'b001_001_001, j == 5, j >= 5);
    end

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].pd, vt[i].op, vt[i].vl);
      @(negedge clk);
      chk($sformatf("vec%0d early err", i), err, 1'b0);
      chk($sformatf("vec%0d early done", i), done, 1'b0);
      chk($sformatf("vec%0d stays idle", i), req_ready, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d err", i), err, vt[i].e_err);
      chk($sformatf("vec%0d done", i), done, vt[i].e_done);
      @(negedge clk);
      chk($sformatf("vec%0d err pulse end", i), err, 1'b0);
      chk($sformatf("vec%0d done pulse end", i), done, 1'b0);
      chk($sformatf("vec%0d pwr", i), pwr, vt[i].e_pwr);
      chk($sformatf("vec%0d clk_en", i), clk_en, 3'b110);
      chk($sformatf("vec%0d iso", i), iso, 3'b001);
      chk($sformatf("vec%0d ret", i), ret, 3'b000);
      chk($sformatf("vec%0d vsel", i), vsel, 9'b001_001_001);
    end

    // pd2 off: retention enabled, isolation skipped
    issue(2'd2, 2'b00, 2'd0);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      seq_chk("off_pd2", j, (j >= 1) ? 3'b010 : 3'b110, 3'b001,
              (j >= 3) ? 3'b100 : 3'b000, (j >= 5) ? 3'b010 : 3'b110,
              9'b001_001_001, j == 5, j >= 5);
    end

    issue(2'd2, 2'b01, 2'd0);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      seq_chk("on_pd2", j, (j >= 5) ? 3'b110 : 3'b010, 3'b001,
              (j >= 3) ? 3'b000 : 3'b100, (j >= 1) ? 3'b110 : 3'b010,
              9'b001_001_001, j == 5, j >= 5);
    end

    // pd1 level 0 -> 2
    issue(2'd1, 2'b10, 2'd2);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      seq_chk("vset_pd1", j, (j >= 1 && j < 7) ? 3'b100 : 3'b110, 3'b001, 3'b000, 3'b110,
              (j < 3) ? 9'b001_001_001 : (j < 5) ? 9'b001_101_001 : 9'b001_100_001,
              j == 7, j >= 7);
    end

    // pd0 on: isolation released, level kept
    issue(2'd0, 2'b01, 2'd0);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      seq_chk("on_pd0", j, (j >= 5) ? 3'b111 : 3'b110, (j >= 3) ? 3'b000 : 3'b001,
              3'b000, (j >= 1) ? 3'b111 : 3'b110, 9'b001_100_001, j == 5, j >= 5);
    end

    // pd0 off, reset pulled low just after edge k+4
    issue(2'd0, 2'b00, 2'd0);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      seq_chk("off_rst", j, (j >= 1) ? 3'b110 : 3'b111, (j >= 3) ? 3'b001 : 3'b000,
              3'b000, 3'b111, 9'b001_100_001, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1 seq_chk("async_rst", 4, 3'b111, 3'b000, 3'b000, 3'b111, 9'b001_001_001, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      seq_chk("post_rst", j, 3'b111, 3'b000, 3'b000, 3'b111, 9'b001_001_001, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
